// File: rtl/q_ttt_pkg.sv
// Shared definitions for the tic-tac-toe Q-learning episode controller:
// cell codes, widths, result codes, FSM states and board cell helpers.
package q_ttt_pkg;

    localparam int BOARD_W = 18;
    localparam int ACT_W   = 4;
    localparam int Q_W     = 8;
    localparam int N_CELLS = 9;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] AGENT = 2'b01;
    localparam logic [1:0] OPP   = 2'b10;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_LOSE = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_AGENT_WAIT = 3'd1,
        S_OPP_WAIT   = 3'd2,
        S_UPDATE     = 3'd3,
        S_WRITE      = 3'd4,
        S_FINISH     = 3'd5
    } st_e;

    // Out-of-range indices read as EMPTY; legality is checked separately.
    function automatic logic [1:0] get_cell(input logic [BOARD_W-1:0] b,
                                            input logic [ACT_W-1:0]   idx);
        logic [1:0] c;
        c = EMPTY;
        for (int i = 0; i < N_CELLS; i++) begin
            if (idx == ACT_W'(i)) c = b[2*i +: 2];
        end
        return c;
    endfunction

    function automatic logic [BOARD_W-1:0] put_cell(input logic [BOARD_W-1:0] b,
                                                    input logic [ACT_W-1:0]   idx,
                                                    input logic [1:0]         code);
        logic [BOARD_W-1:0] r;
        r = b;
        for (int i = 0; i < N_CELLS; i++) begin
            if (idx == ACT_W'(i)) r[2*i +: 2] = code;
        end
        return r;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational line (3 rows, 3 columns, 2 diagonals) and full-board
// detection for one player code on a candidate board.
module ttt_line_check
    import q_ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    input  logic [1:0]         player,
    output logic               line,
    output logic               full
);

    logic [N_CELLS-1:0] own;
    logic [N_CELLS-1:0] filled;

    always_comb begin
        own    = '0;
        filled = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            own[i]    = (board[2*i +: 2] == player);
            filled[i] = (board[2*i +: 2] != EMPTY);
        end
    end

    assign line = (own[0] & own[1] & own[2]) |
                  (own[3] & own[4] & own[5]) |
                  (own[6] & own[7] & own[8]) |
                  (own[0] & own[3] & own[6]) |
                  (own[1] & own[4] & own[7]) |
                  (own[2] & own[5] & own[8]) |
                  (own[0] & own[4] & own[8]) |
                  (own[2] & own[4] & own[6]);

    assign full = &filled;

endmodule

// File: rtl/q_episode_ctrl.sv
// Sequences one tic-tac-toe Q-learning episode around the Q update datapath.
// Optional macro Q_CTRL_STATS_EN adds saturating win/lose/draw counters.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for start; board and result hold last episode
// AGENT_WAIT | act_ready=1, accept and classify the agent action
// OPP_WAIT   | opp_ready=1, accept opponent move; bad moves pulse opp_err
// UPDATE     | dp_* held stable, down-counter runs DP_LAT..0, sample Q_new
// WRITE      | one-cycle Q-table write of the sampled Q_new
// FINISH     | done pulse, return to IDLE
module q_episode_ctrl
    import q_ttt_pkg::*;
#(
    parameter int             DP_LAT    = 1,
    parameter logic [Q_W-1:0] R_WIN     = 8'd10,
    parameter logic [Q_W-1:0] R_DRAW    = 8'd5,
    parameter logic [Q_W-1:0] R_STEP    = 8'd1,
    parameter logic [Q_W-1:0] R_LOSE    = 8'd0,
    parameter logic [Q_W-1:0] R_ILLEGAL = 8'd0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [Q_W-1:0]     gamma_cfg,
    input  logic [Q_W-1:0]     alfa_cfg,
    input  logic               act_valid,
    input  logic [ACT_W-1:0]   act_move,
    output logic               act_ready,
    input  logic               opp_valid,
    input  logic [ACT_W-1:0]   opp_move,
    output logic               opp_ready,
    output logic               opp_err,
    output logic [BOARD_W-1:0] dp_state,
    output logic [BOARD_W-1:0] dp_next_state,
    output logic [ACT_W-1:0]   dp_action,
    output logic [Q_W-1:0]     dp_reward,
    output logic [Q_W-1:0]     dp_gamma,
    output logic [Q_W-1:0]     dp_alfa,
    input  logic [Q_W-1:0]     dp_q_new,
    output logic               qt_we,
    output logic [BOARD_W-1:0] qt_state,
    output logic [ACT_W-1:0]   qt_action,
    output logic [Q_W-1:0]     qt_wdata,
    output logic [BOARD_W-1:0] board,
    output logic               busy,
    output logic               done,
    output logic [1:0]         result
`ifdef Q_CTRL_STATS_EN
    ,
    output logic [15:0]        stat_win,
    output logic [15:0]        stat_lose,
    output logic [15:0]        stat_draw
`endif
);

    localparam int CNT_W = 8;

    st_e state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic               term_r;
    logic               start_ep, take_act, take_opp, opp_bad, sample_q;

    logic               agent_legal, opp_legal;
    logic [BOARD_W-1:0] agent_cand, opp_cand;
    logic               agent_line, agent_full, opp_line, opp_full;

    assign agent_legal = (act_move <= 4'd8) && (get_cell(board, act_move) == EMPTY);
    assign opp_legal   = (opp_move <= 4'd8) && (get_cell(board, opp_move) == EMPTY);
    assign agent_cand  = put_cell(board, act_move, AGENT);
    assign opp_cand    = put_cell(board, opp_move, OPP);

    ttt_line_check u_agent_chk (
        .board  (agent_cand),
        .player (AGENT),
        .line   (agent_line),
        .full   (agent_full)
    );

    ttt_line_check u_opp_chk (
        .board  (opp_cand),
        .player (OPP),
        .line   (opp_line),
        .full   (opp_full)
    );

    assign qt_state  = dp_state;
    assign qt_action = dp_action;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        act_ready = 1'b0;
        opp_ready = 1'b0;
        qt_we     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        start_ep  = 1'b0;
        take_act  = 1'b0;
        take_opp  = 1'b0;
        opp_bad   = 1'b0;
        sample_q  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_ep  = 1'b1;
                    state_nxt = S_AGENT_WAIT;
                end
            end
            S_AGENT_WAIT: begin
                busy      = 1'b1;
                act_ready = 1'b1;
                if (act_valid) begin
                    take_act = 1'b1;
                    if (!agent_legal || agent_line || agent_full) state_nxt = S_UPDATE;
                    else                                          state_nxt = S_OPP_WAIT;
                end
            end
            S_OPP_WAIT: begin
                busy      = 1'b1;
                opp_ready = 1'b1;
                if (opp_valid) begin
                    if (!opp_legal) begin
                        opp_bad = 1'b1;
                    end else begin
                        take_opp  = 1'b1;
                        state_nxt = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    sample_q  = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                qt_we     = 1'b1;
                state_nxt = term_r ? S_FINISH : S_AGENT_WAIT;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            board         <= '0;
            dp_state      <= '0;
            dp_next_state <= '0;
            dp_action     <= '0;
            dp_reward     <= '0;
            dp_gamma      <= '0;
            dp_alfa       <= '0;
            qt_wdata      <= '0;
            result        <= RES_NONE;
            term_r        <= 1'b0;
            cnt           <= '0;
            opp_err       <= 1'b0;
        end else begin
            opp_err <= opp_bad;
            if (start_ep) begin
                board    <= '0;
                dp_gamma <= gamma_cfg;
                dp_alfa  <= alfa_cfg;
                result   <= RES_NONE;
            end
            if (take_act) begin
                dp_state  <= board;
                dp_action <= act_move;
                cnt       <= CNT_W'(DP_LAT);
                if (!agent_legal) begin
                    dp_next_state <= board;
                    dp_reward     <= R_ILLEGAL;
                    term_r        <= 1'b1;
                    result        <= RES_NONE;
                end else begin
                    board         <= agent_cand;
                    dp_next_state <= agent_cand;
                    if (agent_line) begin
                        dp_reward <= R_WIN;
                        term_r    <= 1'b1;
                        result    <= RES_WIN;
                    end else if (agent_full) begin
                        dp_reward <= R_DRAW;
                        term_r    <= 1'b1;
                        result    <= RES_DRAW;
                    end else begin
                        term_r    <= 1'b0;
                    end
                end
            end
            if (take_opp) begin
                board         <= opp_cand;
                dp_next_state <= opp_cand;
                cnt           <= CNT_W'(DP_LAT);
                if (opp_line) begin
                    dp_reward <= R_LOSE;
                    term_r    <= 1'b1;
                    result    <= RES_LOSE;
                end else if (opp_full) begin
                    dp_reward <= R_DRAW;
                    term_r    <= 1'b1;
                    result    <= RES_DRAW;
                end else begin
                    dp_reward <= R_STEP;
                    term_r    <= 1'b0;
                end
            end
            if (state == S_UPDATE && cnt != '0) cnt <= cnt - 1'b1;
            if (sample_q) qt_wdata <= dp_q_new;
        end
    end

`ifdef Q_CTRL_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_win  <= '0;
            stat_lose <= '0;
            stat_draw <= '0;
        end else if (state == S_FINISH) begin
            case (result)
                RES_WIN:  if (stat_win  != 16'hFFFF) stat_win  <= stat_win  + 16'd1;
                RES_LOSE: if (stat_lose != 16'hFFFF) stat_lose <= stat_lose + 16'd1;
                RES_DRAW: if (stat_draw != 16'hFFFF) stat_draw <= stat_draw + 16'd1;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_q_episode_ctrl.sv
// Directed self-checking bench for q_episode_ctrl: a default-latency instance
// for episode scenarios and a DP_LAT=3 instance for update timing.
module tb_q_episode_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic        start = 0, act_valid = 0, opp_valid = 0;
    logic [7:0]  gamma_cfg = 0, alfa_cfg = 0, dp_q_new = 0;
    logic [3:0]  act_move = 0, opp_move = 0;
    logic        act_ready, opp_ready, opp_err, qt_we, busy, done;
    logic [17:0] dp_state, dp_next_state, qt_state, board;
    logic [3:0]  dp_action, qt_action;
    logic [7:0]  dp_reward, dp_gamma, dp_alfa, qt_wdata;
    logic [1:0]  result;

    logic        start_3 = 0, act_valid_3 = 0, opp_valid_3 = 0;
    logic [7:0]  dp_q_new_3 = 0;
    logic [3:0]  act_move_3 = 0, opp_move_3 = 0;
    logic        act_ready_3, opp_ready_3, opp_err_3, qt_we_3, busy_3, done_3;
    logic [17:0] dp_state_3, dp_next_state_3, qt_state_3, board_3;
    logic [3:0]  dp_action_3, qt_action_3;
    logic [7:0]  dp_reward_3, dp_gamma_3, dp_alfa_3, qt_wdata_3;
    logic [1:0]  result_3;

    q_episode_ctrl dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .gamma_cfg(gamma_cfg), .alfa_cfg(alfa_cfg),
        .act_valid(act_valid), .act_move(act_move), .act_ready(act_ready),
        .opp_valid(opp_valid), .opp_move(opp_move), .opp_ready(opp_ready), .opp_err(opp_err),
        .dp_state(dp_state), .dp_next_state(dp_next_state), .dp_action(dp_action),
        .dp_reward(dp_reward), .dp_gamma(dp_gamma), .dp_alfa(dp_alfa), .dp_q_new(dp_q_new),
        .qt_we(qt_we), .qt_state(qt_state), .qt_action(qt_action), .qt_wdata(qt_wdata),
        .board(board), .busy(busy), .done(done), .result(result)
    );

    q_episode_ctrl #(.DP_LAT(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .start(start_3),
        .gamma_cfg(8'h11), .alfa_cfg(8'h22),
        .act_valid(act_valid_3), .act_move(act_move_3), .act_ready(act_ready_3),
        .opp_valid(opp_valid_3), .opp_move(opp_move_3), .opp_ready(opp_ready_3), .opp_err(opp_err_3),
        .dp_state(dp_state_3), .dp_next_state(dp_next_state_3), .dp_action(dp_action_3),
        .dp_reward(dp_reward_3), .dp_gamma(dp_gamma_3), .dp_alfa(dp_alfa_3), .dp_q_new(dp_q_new_3),
        .qt_we(qt_we_3), .qt_state(qt_state_3), .qt_action(qt_action_3), .qt_wdata(qt_wdata_3),
        .board(board_3), .busy(busy_3), .done(done_3), .result(result_3)
    );

    int total = 0;
    int passed = 0;

    // write/done/opp_err recorder for the default-latency instance
    logic [17:0] rec_state [32];
    logic [17:0] rec_next  [32];
    logic [3:0]  rec_act   [32];
    logic [7:0]  rec_rew   [32];
    logic [7:0]  rec_wd    [32];
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0;

    always @(negedge clock) begin
        if (qt_we) begin
            rec_state[wr_cnt % 32] <= qt_state;
            rec_next[wr_cnt % 32]  <= dp_next_state;
            rec_act[wr_cnt % 32]   <= qt_action;
            rec_rew[wr_cnt % 32]   <= dp_reward;
            rec_wd[wr_cnt % 32]    <= qt_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (done)    done_cnt <= done_cnt + 1;
        if (opp_err) err_cnt  <= err_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic begin_episode(input logic [7:0] g, input logic [7:0] a);
        start = 1; gamma_cfg = g; alfa_cfg = a;
        @(posedge clock); #1;
        start = 0;
    endtask

    task automatic agent_play(input logic [3:0] mv);
        int n;
        n = 0;
        act_valid = 1; act_move = mv;
        @(negedge clock);
        while (!act_ready && n < 40) begin @(negedge clock); n++; end
        total++;
        if (n >= 40) $display("FAIL agent_handshake move %0d: act_ready=%b required 1", mv, act_ready);
        else passed++;
        @(posedge clock); #1;
        act_valid = 0;
    endtask

    task automatic opp_play(input logic [3:0] mv);
        int n;
        n = 0;
        opp_valid = 1; opp_move = mv;
        @(negedge clock);
        while (!opp_ready && n < 40) begin @(negedge clock); n++; end
        total++;
        if (n >= 40) $display("FAIL opp_handshake move %0d: opp_ready=%b required 1", mv, opp_ready);
        else passed++;
        @(posedge clock); #1;
        opp_valid = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clock);
        while (!done && n < 60) begin @(negedge clock); n++; end
        total++;
        if (n >= 60) $display("FAIL done_timeout: done=%b required 1", done);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 0;
        #12;
        total++;
        if ({board, busy, act_ready, opp_ready, qt_we, done, result, opp_err} !== '0)
            $display("FAIL reset_ctrl: board=%h busy=%b ar=%b or=%b we=%b done=%b res=%b required all 0",
                     board, busy, act_ready, opp_ready, qt_we, done, result);
        else passed++;
        total++;
        if ({dp_state, dp_next_state, dp_action, dp_reward, dp_gamma, dp_alfa, qt_wdata} !== '0)
            $display("FAIL reset_dp: dp_state=%h next=%h rew=%h gamma=%h wdata=%h required 0",
                     dp_state, dp_next_state, dp_reward, dp_gamma, qt_wdata);
        else passed++;
        @(negedge clock); reset_n = 1;
        tick(2);
        total++;
        if (busy !== 1'b0) $display("FAIL idle_busy: busy=%b required 0", busy);
        else passed++;
    endtask

    task automatic test_win();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        dp_q_new = 8'h33;
        begin_episode(8'h20, 8'h40);
        gamma_cfg = 8'h99; alfa_cfg = 8'h98;
        total++;
        if ({busy, act_ready} !== 2'b11) $display("FAIL win_start: busy=%b act_ready=%b required 1 1", busy, act_ready);
        else passed++;
        agent_play(0); opp_play(4);
        agent_play(1); opp_play(5);
        agent_play(2);
        wait_done();
        total++;
        if ({dp_gamma, dp_alfa} !== 16'h2040) $display("FAIL win_latch: gamma=%h alfa=%h required 20 40", dp_gamma, dp_alfa);
        else passed++;
        total++;
        if (wr_cnt - w0 !== 3) $display("FAIL win_writes: got %0d required 3", wr_cnt - w0);
        else passed++;
        total++;
        if ({rec_rew[w0 % 32], rec_rew[(w0+1) % 32], rec_rew[(w0+2) % 32]} !== {8'd1, 8'd1, 8'd10})
            $display("FAIL win_rewards: got %0d %0d %0d required 1 1 10",
                     rec_rew[w0 % 32], rec_rew[(w0+1) % 32], rec_rew[(w0+2) % 32]);
        else passed++;
        total++;
        if ({rec_state[(w0+1) % 32], rec_state[(w0+2) % 32]} !== {18'h00201, 18'h00A05})
            $display("FAIL win_keys: got %h %h required 00201 00a05", rec_state[(w0+1) % 32], rec_state[(w0+2) % 32]);
        else passed++;
        total++;
        if ({rec_act[(w0+2) % 32], rec_wd[(w0+2) % 32]} !== {4'd2, 8'h33})
            $display("FAIL win_wdata: action=%0d wdata=%h required 2 33", rec_act[(w0+2) % 32], rec_wd[(w0+2) % 32]);
        else passed++;
        // agent on cells 0-2, opponent on 4 and 5
        total++;
        if (board !== 18'b00_00_00_10_10_00_01_01_01) $display("FAIL win_board: got %b required 000000101000010101", board);
        else passed++;
        total++;
        if (result !== 2'b01) $display("FAIL win_result: got %b required 01", result);
        else passed++;
        tick(3);
        total++;
        if (done_cnt - d0 !== 1) $display("FAIL win_done_pulses: got %0d required 1", done_cnt - d0);
        else passed++;
        total++;
        if ({busy, result} !== 3'b001) $display("FAIL win_hold: busy=%b result=%b required 0 01", busy, result);
        else passed++;
    endtask

    task automatic test_illegal();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        begin_episode(8'h01, 8'h02);
        agent_play(0); opp_play(4);
        start = 1;
        @(posedge clock); #1;
        start = 0;
        agent_play(0);
        wait_done();
        total++;
        if (wr_cnt - w0 !== 2) $display("FAIL illegal_writes: got %0d required 2", wr_cnt - w0);
        else passed++;
        total++;
        if ({rec_rew[(w0+1) % 32], rec_state[(w0+1) % 32], rec_next[(w0+1) % 32]} !== {8'd0, 18'h00201, 18'h00201})
            $display("FAIL illegal_update: rew=%0d state=%h next=%h required 0 00201 00201",
                     rec_rew[(w0+1) % 32], rec_state[(w0+1) % 32], rec_next[(w0+1) % 32]);
        else passed++;
        total++;
        if ({board, result} !== {18'h00201, 2'b00})
            $display("FAIL illegal_end: board=%h result=%b required 00201 00", board, result);
        else passed++;
        tick(2);
        total++;
        if (done_cnt - d0 !== 1) $display("FAIL illegal_done: got %0d required 1", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_opp_err();
        int w0, e0;
        w0 = wr_cnt; e0 = err_cnt;
        begin_episode(8'h03, 8'h04);
        agent_play(0);
        opp_play(0);
        total++;
        if ({opp_err, opp_ready} !== 2'b11) $display("FAIL opp_err_occupied: err=%b ready=%b required 1 1", opp_err, opp_ready);
        else passed++;
        opp_play(9);
        total++;
        if ({opp_err, opp_ready} !== 2'b11) $display("FAIL opp_err_range: err=%b ready=%b required 1 1", opp_err, opp_ready);
        else passed++;
        opp_play(4);
        total++;
        if ({opp_err, opp_ready, board} !== {2'b00, 18'h00201})
            $display("FAIL opp_accept: err=%b ready=%b board=%h required 0 0 00201", opp_err, opp_ready, board);
        else passed++;
        agent_play(0);
        wait_done();
        tick(1);
        total++;
        if (err_cnt - e0 !== 2) $display("FAIL opp_err_pulses: got %0d required 2", err_cnt - e0);
        else passed++;
        total++;
        if ({wr_cnt - w0, rec_rew[w0 % 32]} !== {32'd2, 8'd1})
            $display("FAIL opp_err_writes: writes=%0d reward=%0d required 2 1", wr_cnt - w0, rec_rew[w0 % 32]);
        else passed++;
    endtask

    task automatic test_draw();
        int w0;
        w0 = wr_cnt;
        begin_episode(8'h05, 8'h06);
        agent_play(0); opp_play(1);
        agent_play(2); opp_play(4);
        agent_play(3); opp_play(5);
        agent_play(7); opp_play(6);
        agent_play(8);
        wait_done();
        total++;
        if (wr_cnt - w0 !== 5) $display("FAIL draw_writes: got %0d required 5", wr_cnt - w0);
        else passed++;
        total++;
        if ({rec_rew[w0 % 32], rec_rew[(w0+3) % 32], rec_rew[(w0+4) % 32]} !== {8'd1, 8'd1, 8'd5})
            $display("FAIL draw_rewards: got %0d %0d %0d required 1 1 5",
                     rec_rew[w0 % 32], rec_rew[(w0+3) % 32], rec_rew[(w0+4) % 32]);
        else passed++;
        total++;
        if ({rec_state[(w0+4) % 32], rec_next[(w0+4) % 32]} !== {18'b00_01_10_10_10_01_01_10_01, 18'b01_01_10_10_10_01_01_10_01})
            $display("FAIL draw_last_key: state=%b next=%b", rec_state[(w0+4) % 32], rec_next[(w0+4) % 32]);
        else passed++;
        total++;
        if (result !== 2'b11) $display("FAIL draw_result: got %b required 11", result);
        else passed++;
    endtask

    task automatic test_latency();
        int n, k, bad;
        logic seen;
        start_3 = 1;
        @(posedge clock); #1;
        start_3 = 0;
        act_valid_3 = 1; act_move_3 = 0; n = 0;
        @(negedge clock);
        while (!act_ready_3 && n < 20) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        act_valid_3 = 0;
        opp_valid_3 = 1; opp_move_3 = 4;
        @(negedge clock);
        while (!opp_ready_3 && n < 40) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        opp_valid_3 = 0;
        total++;
        if (n >= 40) $display("FAIL lat_handshake: ready timeout after %0d cycles", n);
        else passed++;
        k = 0; bad = 0; seen = 0;
        while (k < 20 && !seen) begin
            @(negedge clock);
            k++;
            if (qt_we_3) seen = 1;
            else begin
                if ({dp_state_3, dp_next_state_3, dp_action_3, dp_reward_3} !== {18'h0, 18'h00201, 4'd0, 8'd1}) bad++;
                dp_q_new_3 = 8'h10 + 8'(k);
            end
        end
        total++;
        if (k !== 5) $display("FAIL lat_cycles: qt_we after %0d cycles required 5", k);
        else passed++;
        total++;
        if (bad !== 0) $display("FAIL lat_stable: %0d unstable dp cycles required 0", bad);
        else passed++;
        total++;
        if ({qt_wdata_3, qt_state_3, qt_action_3} !== {8'h14, 18'h0, 4'd0})
            $display("FAIL lat_wdata: wdata=%h state=%h action=%0d required 14 0 0", qt_wdata_3, qt_state_3, qt_action_3);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        begin_episode(8'h5A, 8'hA5);
        agent_play(0); opp_play(4);
        #2;
        reset_n = 0;
        #1;
        total++;
        if ({board, busy, act_ready, opp_ready, qt_we, done, result, opp_err} !== '0)
            $display("FAIL mid_reset_ctrl: board=%h busy=%b we=%b result=%b required all 0", board, busy, qt_we, result);
        else passed++;
        total++;
        if ({dp_state, dp_next_state, dp_action, dp_reward, dp_gamma, dp_alfa, qt_wdata} !== '0)
            $display("FAIL mid_reset_dp: next=%h rew=%h gamma=%h alfa=%h required 0", dp_next_state, dp_reward, dp_gamma, dp_alfa);
        else passed++;
        repeat (3) @(posedge clock);
        @(negedge clock); reset_n = 1;
        tick(3);
        total++;
        if ({wr_cnt - w0, done_cnt - d0} !== 64'd0)
            $display("FAIL mid_reset_abort: writes=%0d dones=%0d required 0 0", wr_cnt - w0, done_cnt - d0);
        else passed++;
        begin_episode(8'h07, 8'h08);
        total++;
        if ({board, busy, act_ready} !== {18'h0, 2'b11})
            $display("FAIL fresh_start: board=%h busy=%b act_ready=%b required 0 1 1", board, busy, act_ready);
        else passed++;
        agent_play(4);
        total++;
        if ({board, dp_state, opp_ready} !== {18'h00100, 18'h0, 1'b1})
            $display("FAIL fresh_move: board=%h dp_state=%h opp_ready=%b required 00100 0 1", board, dp_state, opp_ready);
        else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_win();
        test_illegal();
        test_opp_err();
        test_draw();
        test_latency();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
